// File: rtl/pc_unit_pkg.sv
// Shared fetch-stage constants and types for the PC unit.
// Holds the reset, exception-entry and instruction-memory window addresses.
// The CP0 and IM models use the same values, so the addresses stay consistent.
// Also defines the next-PC select encoding.
package pc_unit_pkg;

   localparam int unsigned PC_WIDTH       = 32;
   localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_3000;
   localparam logic [31:0] EXC_ENTRY_DEF  = 32'h0000_4180;
   localparam logic [31:0] IM_BASE_DEF    = 32'h0000_3000;
   localparam logic [31:0] IM_BYTES_DEF   = 32'h0000_4000;

   // Next-PC source, listed in priority order
   typedef enum logic [2:0] {
      SEL_EXC   = 3'd0,
      SEL_ERET  = 3'd1,
      SEL_HOLD  = 3'd2,
      SEL_SLOT  = 3'd3,
      SEL_REDIR = 3'd4,
      SEL_SEQ   = 3'd5
   } npc_sel_e;

endpackage

// File: rtl/pc_unit_if.sv
// Fetch-control bundle between the pipeline control logic and the PC unit.
// master : pipeline control. It drives stall, redirect, exception and eret requests,
//          and observes PC, PC_plus4, F_adel and redir_pend.
// slave  : the PC unit, which drives PC, PC_plus4, F_adel and redir_pend.
interface pc_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             stall;
   logic             redir_en;
   logic [WIDTH-1:0] redir_pc;
   logic             exc_req;
   logic             eret_req;
   logic [WIDTH-1:0] epc;
   logic [WIDTH-1:0] PC;
   logic [WIDTH-1:0] PC_plus4;
   logic             F_adel;
   logic             redir_pend;

   modport master (
      output stall, redir_en, redir_pc, exc_req, eret_req, epc,
      input  PC, PC_plus4, F_adel, redir_pend
   );

   modport slave (
      input  stall, redir_en, redir_pc, exc_req, eret_req, epc,
      output PC, PC_plus4, F_adel, redir_pend
   );
endinterface

// File: rtl/pc_redir_slot.sv
// One-entry redirect holding register (valid flag plus target address).
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   load         capture load_target and set valid; a newer target overwrites the old one
//   clear        drop the entry; load wins if both load and clear are high
//   load_target  redirect target to store
//   valid        entry occupied
//   target       stored target
module pc_redir_slot #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] load_target,
   output logic             valid,
   output logic [WIDTH-1:0] target
);

   // Slot state
   always_ff @(posedge clk) begin
      if (reset) begin
         valid  <= 1'b0;
         target <= '0;
      end else if (load) begin
         valid  <= 1'b1;
         target <= load_target;
      end else if (clear) begin
         valid  <= 1'b0;
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter for the pipelined MIPS core.
// Picks the next PC from these sources: exception entry, eret, stall hold,
// the pending redirect, a live redirect, and PC+4.
// Ports:
//   Clk    clock; all state changes on the rising edge
//   Reset  synchronous, active-high; loads RESET_ADDR and empties the redirect slot
//   bus    pc_unit_if.slave, carrying these signals:
//          stall, redir_en/redir_pc, exc_req, eret_req/epc  (inputs)
//          PC, PC_plus4, F_adel, redir_pend                  (outputs)
module pc_unit
   import pc_unit_pkg::*;
#(
   parameter int unsigned     WIDTH      = PC_WIDTH,
   parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(RESET_ADDR_DEF),
   parameter logic [WIDTH-1:0] EXC_ENTRY  = WIDTH'(EXC_ENTRY_DEF),
   parameter logic [WIDTH-1:0] IM_BASE    = WIDTH'(IM_BASE_DEF),
   parameter logic [WIDTH:0]   IM_BYTES   = (WIDTH+1)'(IM_BYTES_DEF)
) (
   input  logic      Clk,
   input  logic      Reset,
   pc_unit_if.slave  bus
);

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_d;
   logic [WIDTH-1:0] pc_plus4;
   logic [WIDTH-1:0] slot_target;
   logic             slot_valid;
   logic             slot_load;
   logic             slot_clear;
   logic [WIDTH:0]   win_end;
   npc_sel_e         sel;

   // Redirect slot: holds a redirect that arrives while the PC is stalled
   pc_redir_slot #(.WIDTH(WIDTH)) u_slot (
      .clk         (Clk),
      .reset       (Reset),
      .load        (slot_load),
      .clear       (slot_clear),
      .load_target (bus.redir_pc),
      .valid       (slot_valid),
      .target      (slot_target)
   );

   // Next-PC source select and slot control, in priority order
   always_comb begin
      sel        = SEL_SEQ;
      slot_load  = 1'b0;
      slot_clear = 1'b0;
      if (bus.exc_req) begin
         sel        = SEL_EXC;
         slot_clear = 1'b1;
      end else if (bus.eret_req) begin
         sel        = SEL_ERET;
         slot_clear = 1'b1;
      end else if (bus.stall) begin
         sel        = SEL_HOLD;
         slot_load  = bus.redir_en;
      end else if (slot_valid) begin
         // A redirect arriving in the same cycle is newer than the stored one
         sel        = bus.redir_en ? SEL_REDIR : SEL_SLOT;
         slot_clear = 1'b1;
      end else if (bus.redir_en) begin
         sel        = SEL_REDIR;
      end
   end

   // Next-PC mux
   always_comb begin
      pc_d = pc_plus4;
      case (sel)
         SEL_EXC:   pc_d = EXC_ENTRY;
         SEL_ERET:  pc_d = bus.epc;
         SEL_HOLD:  pc_d = pc_q;
         SEL_SLOT:  pc_d = slot_target;
         SEL_REDIR: pc_d = bus.redir_pc;
         default:   pc_d = pc_plus4;
      endcase
   end

   // PC register
   always_ff @(posedge Clk) begin
      if (Reset) pc_q <= RESET_ADDR;
      else       pc_q <= pc_d;
   end

   // PC+4 wraps modulo 2^WIDTH
   assign pc_plus4 = pc_q + WIDTH'(4);

   // The window end is one bit wider so that base+size = 2^WIDTH does not overflow
   assign win_end = {1'b0, IM_BASE} + IM_BYTES;

   assign bus.PC         = pc_q;
   assign bus.PC_plus4   = pc_plus4;
   assign bus.redir_pend = slot_valid;
   assign bus.F_adel     = (|pc_q[1:0]) | (pc_q < IM_BASE) | ({1'b0, pc_q} >= win_end);

endmodule

// File: tb/tb_pc_unit.sv
// Directed-vector bench for pc_unit.
// Each row is one clock cycle: the inputs driven and the state expected after the edge.
module tb_pc_unit;
   import pc_unit_pkg::*;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        redir_en;
      logic [31:0] redir_pc;
      logic        exc;
      logic        eret;
      logic [31:0] epc;
      logic [31:0] exp_pc;
      logic        exp_pend;
      logic        exp_adel;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   vec_t vecs[$];

   pc_unit_if #(.WIDTH(32)) bus ();

   pc_unit dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic r, logic s, logic re, logic [31:0] rp,
                               logic e, logic er, logic [31:0] ep,
                               logic [31:0] pc, logic pend, logic adel);
      vec_t v;
      v.rst = r; v.stall = s; v.redir_en = re; v.redir_pc = rp;
      v.exc = e; v.eret = er; v.epc = ep;
      v.exp_pc = pc; v.exp_pend = pend; v.exp_adel = adel;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      @(negedge clk);
      rst          = v.rst;
      bus.stall    = v.stall;
      bus.redir_en = v.redir_en;
      bus.redir_pc = v.redir_pc;
      bus.exc_req  = v.exc;
      bus.eret_req = v.eret;
      bus.epc      = v.epc;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(mk(0,0,0,32'h0,0,0,32'h0, 32'h0,0,0));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.stall = 1'b0; bus.redir_en = 1'b0; bus.redir_pc = '0;
      bus.exc_req = 1'b0; bus.eret_req = 1'b0; bus.epc = '0;

      //              rst stl ren redir_pc      exc ert epc            pc           pnd adel
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h3000,      0, 0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h3000,      0, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h3004,      0, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h3008,      0, 0));
      vecs.push_back(mk(0, 0, 1, 32'h3100,     0, 0, 32'h0,        32'h3100,      0, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h3104,      0, 0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h3104,      0, 0));
      vecs.push_back(mk(0, 1, 1, 32'h3200,     0, 0, 32'h0,        32'h3104,      1, 0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h3104,      1, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h3200,      0, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h3204,      0, 0));
      vecs.push_back(mk(0, 1, 1, 32'h3300,     0, 0, 32'h0,        32'h3204,      1, 0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        1, 0, 32'h0,        32'h4180,      0, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h3010,     32'h3010,      0, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h3020,     32'h4180,      0, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h3010,     32'h3010,      0, 0));
      vecs.push_back(mk(0, 0, 1, 32'h3102,     0, 0, 32'h0,        32'h3102,      0, 1));
      vecs.push_back(mk(0, 0, 1, 32'h2FFC,     0, 0, 32'h0,        32'h2FFC,      0, 1));
      vecs.push_back(mk(0, 0, 1, 32'h6FFC,     0, 0, 32'h0,        32'h6FFC,      0, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h7000,      0, 1));
      vecs.push_back(mk(0, 1, 1, 32'h3400,     0, 0, 32'h0,        32'h7000,      1, 1));
      vecs.push_back(mk(0, 0, 1, 32'h3500,     0, 0, 32'h0,        32'h3500,      0, 0));
      vecs.push_back(mk(0, 1, 1, 32'h3600,     0, 0, 32'h0,        32'h3500,      1, 0));
      vecs.push_back(mk(0, 1, 1, 32'h3700,     0, 0, 32'h0,        32'h3500,      1, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h3700,      0, 0));
      vecs.push_back(mk(0, 1, 1, 32'h3800,     0, 0, 32'h0,        32'h3700,      1, 0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0, 1, 32'h3020,     32'h3020,      0, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h3024,      0, 0));
      vecs.push_back(mk(0, 1, 1, 32'h3900,     0, 0, 32'h0,        32'h3024,      1, 0));
      vecs.push_back(mk(1, 1, 0, 32'h0,        0, 0, 32'h0,        32'h3000,      0, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h3004,      0, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h3011,     32'h3011,      0, 1));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h3015,      0, 1));

      foreach (vecs[i]) begin
         drive(vecs[i]);
         chk($sformatf("v%0d.pc", i),    bus.PC,                  vecs[i].exp_pc);
         chk($sformatf("v%0d.plus4", i), bus.PC_plus4,            vecs[i].exp_pc + 32'd4);
         chk($sformatf("v%0d.pend", i),  32'(bus.redir_pend),     32'(vecs[i].exp_pend));
         chk($sformatf("v%0d.adel", i),  32'(bus.F_adel),         32'(vecs[i].exp_adel));
      end

      // Two reset cycles followed by three free-running cycles
      drive(mk(1,0,0,32'h0,0,0,32'h0, 32'h0,0,0));
      drive(mk(1,0,0,32'h0,0,0,32'h0, 32'h0,0,0));
      idle(); idle(); idle();
      chk("free3.pc",   bus.PC,              32'h300C);
      chk("free3.pend", 32'(bus.redir_pend), 32'h0);

      // PC+4 wraps past the top of the address space
      drive(mk(0,0,1,32'hFFFF_FFFC,0,0,32'h0, 32'h0,0,0));
      chk("wrap.pc",    bus.PC,          32'hFFFF_FFFC);
      chk("wrap.plus4", bus.PC_plus4,    32'h0000_0000);
      chk("wrap.adel",  32'(bus.F_adel), 32'h1);
      idle();
      chk("wrap.next",  bus.PC,          32'h0000_0000);
      chk("wrap.adel0", 32'(bus.F_adel), 32'h1);
      drive(mk(0,0,0,32'h0,1,0,32'h0, 32'h0,0,0));
      chk("wrap.exc",   bus.PC,          32'h4180);
      chk("wrap.exc_adel", 32'(bus.F_adel), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
